// File: rtl/mips_avalon_arbiter.sv
// mips_avalon_arbiter
// Arbitrates between a MIPS instruction-fetch port and a data port and maps
// the winner onto a single Avalon-MM master. Only one transfer is outstanding
// at a time. A transfer that stalls for MAX_WAIT consecutive cycles is
// aborted: it completes with err and returns 32'hDEADBEEF as its data.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   i_req/i_addr               fetch request (held until i_ack)
//   i_ack/i_rdata              fetch completion pulse and data
//   d_req/d_we/d_addr/
//   d_wdata/d_be               data-port request (held until d_ack)
//   d_ack/d_rdata              data completion pulse and load data
//   err                        pulses with an ack when the transfer timed out
//   address/read/write/
//   writedata/byteenable       Avalon master command (all registered)
//   waitrequest/readdata       Avalon slave response
module mips_avalon_arbiter #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS_I = 2'd1,
        ST_BUS_D = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // Counter value at which one more stalled cycle reaches MAX_WAIT.
    localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);
    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

    state_t      state_q, state_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] address_q, address_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        err_q, err_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        last_d_q, last_d_d;   // 1 = data port granted most recently
    logic        grant_d_s;

    assign i_ack      = i_ack_q;
    assign i_rdata    = i_rdata_q;
    assign d_ack      = d_ack_q;
    assign d_rdata    = d_rdata_q;
    assign err        = err_q;
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;

    // Data wins a tie unless it was the port served last.
    assign grant_d_s = d_req & (~i_req | ~last_d_q);

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_d      = state_q;
        read_d       = read_q;
        write_d      = write_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        err_d        = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        wait_cnt_d   = wait_cnt_q;
        last_d_d     = last_d_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_d_s) begin
                    state_d      = ST_BUS_D;
                    address_d    = d_addr;
                    read_d       = ~d_we;
                    write_d      = d_we;
                    writedata_d  = d_wdata;
                    byteenable_d = d_be;
                    wait_cnt_d   = 16'd0;
                    last_d_d     = 1'b1;
                end else if (i_req) begin
                    state_d      = ST_BUS_I;
                    address_d    = i_addr;
                    read_d       = 1'b1;
                    write_d      = 1'b0;
                    writedata_d  = 32'd0;
                    byteenable_d = 4'hF;
                    wait_cnt_d   = 16'd0;
                    last_d_d     = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BUS_I, ST_BUS_D: begin
                if (!waitrequest) begin
                    // Slave accepted: drop strobes, capture load data, ack.
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = ST_ACK;
                    if (state_q == ST_BUS_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = readdata;
                    end else begin
                        d_ack_d = 1'b1;
                        if (read_q) begin
                            d_rdata_d = readdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // This stalled cycle brings the count to MAX_WAIT: abort.
                    read_d     = 1'b0;
                    write_d    = 1'b0;
                    err_d      = 1'b1;
                    wait_cnt_d = wait_cnt_q + 16'd1;
                    state_d    = ST_ACK;
                    if (state_q == ST_BUS_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = ABORT_DATA;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = ABORT_DATA;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end

            // No grant here, so a request still high in the ack cycle is not
            // served twice.
            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= 32'd0;
            writedata_q  <= 32'd0;
            byteenable_q <= 4'd0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            err_q        <= 1'b0;
            i_rdata_q    <= 32'd0;
            d_rdata_q    <= 32'd0;
            wait_cnt_q   <= 16'd0;
            last_d_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            read_q       <= read_d;
            write_q      <= write_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            err_q        <= err_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            wait_cnt_q   <= wait_cnt_d;
            last_d_q     <= last_d_d;
        end
    end

endmodule
